// File: rtl/ps2_rx_fifo_if.sv
// ----------------------------------------------------------------------------
// ps2_rx_fifo_if
// Bus-side signal bundle between the PS/2 receiver FIFO and MIO_BUS.
//   ps2_rd     : one-cycle pop strobe (bus -> receiver)
//   clr_err    : one-cycle clear of overflow/frame_err/err_count (bus -> receiver)
//   key        : FIFO head {brk, ext, code[7:0]}, valid while ps2_ready=1
//   ps2_ready  : FIFO not empty
//   fifo_count : number of entries held, 0..FIFO_DEPTH
//   overflow   : sticky, a completed code was dropped on a full FIFO
//   frame_err  : sticky, parity/start/stop/timeout error seen
//   err_count  : saturating frame error count
// Modports: master = bus/CPU side, slave = receiver side.
// FIFO_DEPTH must match the receiver instance it is connected to.
// ----------------------------------------------------------------------------
interface ps2_rx_fifo_if #(
    parameter int FIFO_DEPTH = 16
) ();
    logic                          ps2_rd;
    logic                          clr_err;
    logic [9:0]                    key;
    logic                          ps2_ready;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          overflow;
    logic                          frame_err;
    logic [7:0]                    err_count;

    modport master (
        output ps2_rd, clr_err,
        input  key, ps2_ready, fifo_count, overflow, frame_err, err_count
    );

    modport slave (
        input  ps2_rd, clr_err,
        output key, ps2_ready, fifo_count, overflow, frame_err, err_count
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// ----------------------------------------------------------------------------
// ps2_rx_fifo
// PS/2 keyboard receiver: synchronises the raw pins, glitch-filters the PS/2
// clock, deframes 11-bit frames (start, 8 data LSB first, odd parity, stop)
// with a frame timeout, and buffers scan codes in a first-word-fall-through
// FIFO read over MIO_BUS.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   PS2_clk   : raw PS/2 clock pin (asynchronous)
//   PS2_Data  : raw PS/2 data pin (asynchronous)
//   bus       : ps2_rx_fifo_if.slave (ps2_rd, clr_err, key, ps2_ready,
//               fifo_count, overflow, frame_err, err_count)
// Optional feature macro: PS2_BREAK_TAG_EN
//   defined   : E0/F0 prefixes are absorbed into ext/brk tag bits of the next code
//   undefined : every code is pushed raw as {2'b00, code}
// ----------------------------------------------------------------------------
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH  = 16,
    parameter int CLK_FILTER  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         PS2_clk,
    input  logic         PS2_Data,
    ps2_rx_fifo_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = $clog2(CLK_FILTER);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and clock glitch filter
    // ------------------------------------------------------------------
    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fe_q;
    logic          dat;

    assign dat = dat_sync_q[1];

    // The count tracks consecutive samples that disagree with the filtered
    // level; the level flips on the CLK_FILTER-th one.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (fcnt_q == FW'(CLK_FILTER - 1))
                filt_d = clk_sync_q[1];
            else
                fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            fe_q       <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], PS2_clk};
            dat_sync_q <= {dat_sync_q[0], PS2_Data};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            fe_q       <= filt_q & ~filt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          push_q, push_d;
    logic [9:0]    push_val_q, push_val_d;
    logic          err_q, err_d;
    logic          frame_ok;
`ifdef PS2_BREAK_TAG_EN
    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
`endif

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        timer_d    = '0;
        push_d     = 1'b0;
        push_val_d = push_val_q;
        err_d      = 1'b0;
        frame_ok   = 1'b0;
`ifdef PS2_BREAK_TAG_EN
        ext_d      = ext_q;
        brk_d      = brk_q;
`endif
        if (fe_q) begin
            case (state_q)
                IDLE: begin
                    if (!dat) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d  = {dat, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7)
                        state_d = PARITY;
                end
                PARITY: begin
                    par_d   = dat;
                    state_d = STOP;
                end
                STOP: begin
                    if (dat && (^{shift_q, par_q}))
                        frame_ok = 1'b1;
                    else
                        err_d = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end

`ifdef PS2_BREAK_TAG_EN
        if (frame_ok) begin
            if (shift_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push_d     = 1'b1;
                push_val_d = {brk_q, ext_q, shift_q};
                ext_d      = 1'b0;
                brk_d      = 1'b0;
            end
        end
        if (err_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
`else
        if (frame_ok) begin
            push_d     = 1'b1;
            push_val_d = {2'b00, shift_q};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            timer_q    <= '0;
            push_q     <= 1'b0;
            push_val_q <= '0;
            err_q      <= 1'b0;
`ifdef PS2_BREAK_TAG_EN
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            timer_q    <= timer_d;
            push_q     <= push_d;
            push_val_q <= push_val_d;
            err_q      <= err_d;
`ifdef PS2_BREAK_TAG_EN
            ext_q      <= ext_d;
            brk_q      <= brk_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO and sticky error flags
    // ------------------------------------------------------------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop, full, wr_en, ovf_ev;
    logic          ovf_q, ovf_d;
    logic          ferr_q, ferr_d;
    logic [7:0]    ecnt_q, ecnt_d;

    // A pop on a full FIFO frees the slot the same-cycle push needs.
    assign pop    = bus.ps2_rd && (count_q != '0);
    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign wr_en  = push_q && (!full || pop);
    assign ovf_ev = push_q && full && !pop;

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + CW'(wr_en) - CW'(pop);

        ovf_d  = ovf_q | ovf_ev;
        ferr_d = ferr_q | err_q;
        ecnt_d = (err_q && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
        // A clear loses to an event arriving in the same cycle.
        if (bus.clr_err) begin
            ovf_d  = ovf_ev;
            ferr_d = err_q;
            ecnt_d = err_q ? 8'd1 : 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= push_val_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign bus.key        = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign bus.ps2_ready  = (count_q != '0);
    assign bus.fifo_count = count_q;
    assign bus.overflow   = ovf_q;
    assign bus.frame_err  = ferr_q;
    assign bus.err_count  = ecnt_q;

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver. It is the successor to the single-key latch used in the current PS2_IO path. It samples the raw PS2_clk/PS2_Data pins, glitch-filters the clock and deframes 11-bit frames with parity and timeout checking. Scan codes are buffered in a first-word-fall-through FIFO, so the CPU can read them through MIO_BUS without losing keystrokes between polls. It sits on the CPU clock domain beside MIO_BUS; ps2_ready and key feed the bus read mux, and ps2_rd is the bus read strobe.

Parameters:
FIFO_DEPTH, 16, number of FIFO entries; power of two, 2..256.
CLK_FILTER, 8, consecutive equal samples needed before the filtered PS2 clock changes level; 2..64.
TIMEOUT_CYC, 20000, clk cycles without a filtered falling edge before a partial frame is abandoned.

Ports:
clk  input  1  system clock, all logic rising-edge.
rst  input  1  asynchronous, active-low reset.
PS2_clk  input  1  raw PS/2 clock pin, asynchronous.
PS2_Data  input  1  raw PS/2 data pin, asynchronous.
ps2_rd  input  1  one-cycle pop strobe from MIO_BUS.
clr_err  input  1  one-cycle clear of overflow, frame_err and err_count.
key  output  10  FIFO head {brk, ext, code[7:0]}; valid while ps2_ready=1.
ps2_ready  output  1  FIFO not empty.
fifo_count  output  $clog2(FIFO_DEPTH)+1  number of entries held.
overflow  output  1  sticky; a completed code was dropped because the FIFO was full.
frame_err  output  1  sticky; a parity, start, stop or timeout error occurred.
err_count  output  8  saturating count of frame errors (stops at 255).

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE and the FIFO is emptied.
  - Outputs: key=0, ps2_ready=0, fifo_count=0, overflow=0, frame_err=0, err_count=0.
  - Synchronisers load 1 and the filtered clock loads 1.
  - Prefix flags are cleared.
  - Any partial frame is discarded.
- Input path: a 2-FF synchroniser on each pin. The filtered clock takes the synchronised value after CLK_FILTER consecutive identical samples. A falling edge is filtered 1->0, detected as a registered one-cycle strobe fe.
- Data is sampled from the synchronised PS2_Data in the cycle fe=1.
- FSM states and transitions, all advanced on fe only:
  - IDLE: data=0 -> DATA with bit counter 0; data=1 -> frame error, stay IDLE.
  - DATA: shift LSB first; after 8 bits -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: if data=1 and odd parity holds over code+parity, the code is complete; otherwise frame error. Either way -> IDLE.
- Timeout: in any non-IDLE state, a timer counts cycles since the last fe. Reaching TIMEOUT_CYC -> frame error, go to IDLE. The timer resets on every fe.
- Frame error: frame_err is set and err_count is incremented (saturating). Nothing is pushed.
- Push timing: a completed code is pushed in the cycle after the STOP fe. ps2_ready and fifo_count reflect it in the following cycle. Latency from the STOP fe to ps2_ready=1 is 2 clk.
- FIFO is first-word-fall-through: key always shows the head, and ps2_rd advances the head on the next edge.
- ps2_rd with an empty FIFO is ignored; no underflow and no state change.
- Push while full, no pop in the same cycle: the new code is dropped, overflow is set, and stored data is unchanged.
- Push and pop in the same cycle while full: the pop happens, the push succeeds, fifo_count is unchanged, and overflow is not set.
- Push and pop in the same cycle while empty: the push succeeds and the pop is ignored; fifo_count becomes 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- clr_err clears overflow, frame_err and err_count next cycle. If an error event occurs in the same cycle, the event wins: flag=1, err_count=1.

Optional Feature:
PS2_BREAK_TAG_EN
- Defined:
  - Code 0xE0 sets ext_pend and is not pushed.
  - Code 0xF0 sets brk_pend and is not pushed.
  - Any other code is pushed as {brk_pend, ext_pend, code}, then both pend flags clear.
  - A frame error clears both pend flags.
- Undefined: every code is pushed raw as {2'b00, code}, including E0 and F0; no pend flags exist.

Test Plan:
- Reset, then one valid frame 0x1C (parity 0, stop 1) -> ps2_ready=1 two cycles after the stop edge; key=0x01C; fifo_count=1; ps2_rd pulse -> ps2_ready=0, fifo_count=0.
- Frame 0x1C with parity bit forced to 1 -> frame_err=1, err_count=1, ps2_ready stays 0. clr_err -> both cleared.
- 17 valid frames 0x01..0x11 with FIFO_DEPTH=16 and no reads -> fifo_count=16, overflow=1; reads return 0x01..0x10 in order; 0x11 is lost.
- FIFO full, ps2_rd asserted in the push cycle of a new frame 0x22 -> fifo_count stays 16, overflow=0, last read after draining returns 0x22.
- Start bit plus 3 data bits, then clock held high for TIMEOUT_CYC cycles -> frame_err=1, FSM back to IDLE; next valid frame 0x1C is received correctly.
- With PS2_BREAK_TAG_EN: frames E0, F0, 0x75 -> a single entry key=0x375. Without the macro -> three entries 0x0E0, 0x0F0, 0x075.
